mem_arbiter: RTL
================

# mem_arbiter

Arbitrates the single byte-wide main-memory port between the instruction cache and the MEM stage, and sequences each 1/2/4-byte access as back-to-back single-byte RAM cycles. Sits between `i_cache`/MEM stage and the RAM: the cache sees a busy/enable handshake, the RAM sees one address per cycle with one-cycle read latency.

## Interface
- `ADDR_WIDTH`, 32, byte address width on all ports.
- `DATA_FIRST`, 1, 1: MEM stage wins simultaneous requests; 0: instruction wins.

- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-low.
- `inst_read_i` in 1 — i-cache miss request; held with address until `inst_enable_o`.
- `inst_addr_i` in ADDR_WIDTH — word-aligned fetch address.
- `inst_cancel_i` in 1 — branch flush; abandons an inst fetch.
- `inst_busy` out 1 — controller not in IDLE.
- `inst_enable_o` out 1 — one-cycle pulse, `inst_data_o` valid.
- `inst_data_o` out 32 — fetched word, little-endian.
- `data_read_i` / `data_write_i` in 1 each — MEM stage request, held until `data_enable_o`.
- `data_addr_i` in ADDR_WIDTH; `data_wdata_i` in 32; `data_len_i` in 2 — 00 byte, 01 half, 10/11 word.
- `data_busy` out 1 — same as `inst_busy`.
- `data_enable_o` out 1 — one-cycle completion pulse (read and write).
- `data_rdata_o` out 32 — zero-extended read result.
- `mem_a` out ADDR_WIDTH; `mem_dout` out 8; `mem_wr` out 1 (1 = write); `mem_din` in 8.

## Operation
- States: IDLE, READ, WRITE; owner flag INST/DATA; byte counter `cnt` 0..3; length N = 1, 2 or 4.
- IDLE: sample requests each edge. Write beats read if both MEM bits set. Simultaneous inst+data: per `DATA_FIRST`. Loser keeps its request asserted; no queue.
- Grant: latch owner, address, N, write data; go READ or WRITE.
- READ: drive `mem_a = addr + k` for k = 0..N-1; byte k returns on `mem_din` one cycle later and lands in bits [8k+7:8k]; upper bytes zero.
- WRITE: drive `mem_a = addr + k`, `mem_dout = wdata[8k+7:8k]`, `mem_wr = 1` for k = 0..N-1.
- Completion: assert owner's enable with data, return to IDLE. Non-owner enable never pulses.
- Non-preemptive: a granted access runs to completion; only `inst_cancel_i` aborts, and only an INST-owned READ — next edge returns to IDLE, no `inst_enable_o`, in-flight RAM read discarded. Cancel ignored for DATA ownership or in IDLE.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Reset (any time, incl. mid-transfer): state IDLE, all outputs 0 (`mem_a` 0, `mem_wr` 0, enables 0, data outputs 0, busy 0); partial data discarded.

## Timing
- All outputs registered. T0 = cycle request is seen in IDLE.
- Read: `mem_a` byte k during T1+k; byte k captured at end of T2+k; enable high during T(N+2), busy high T1..T(N+1). Word read: enable in T6.
- Write: `mem_wr` high T1..TN; enable high during T(N+1); busy T1..TN.
- Enable cycle is IDLE: a new request can be granted at its end (back-to-back, no bubble).
- `mem_wr` 0 in every non-write cycle; `mem_dout` 0 when not writing.

## Structure
- `defines.vh`: state encodings, `data_len_i` codes, owner encoding, reuse `InstAddrBus`, `ZeroWord`.
- Single module; no sub-module needed — byte shifter inline.

## Test plan
- Reset mid-READ of word at 0x100 -> next cycle all outputs 0, busy 0, no enable after release.
- Inst read 0x1000, RAM bytes 13,05,00,00 -> `mem_a` 0x1000..0x1003 T1–T4, `inst_enable_o` T6, `inst_data_o` 0x00000513.
- Same-cycle inst 0x20 and data byte read 0x104 (`DATA_FIRST`=1) -> data served first (enable T3), inst granted T3, `inst_enable_o` T9.
- Half write 0xDEADBEEF to 0x200 -> T1 {0x200,0xEF,wr}, T2 {0x201,0xBE,wr}, `data_enable_o` T3, no write to 0x202.
- `inst_cancel_i` in T2 of inst word read -> IDLE at T3, no `inst_enable_o`; pending data request granted at end of T3.
- Word read at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-wide memory port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  // data_len_i codes; 2'b11 is treated as a word as well
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Number of single-byte RAM beats for a given length code
  function automatic logic [2:0] len_to_beats(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

  // Byte k of a little-endian word
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and the MEM
// stage, splitting each 1/2/4-byte access into back-to-back byte cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_read_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  input  logic                  inst_cancel_i,
  output logic                  inst_busy,
  output logic                  inst_enable_o,
  output logic [31:0]           inst_data_o,
  input  logic                  data_read_i,
  input  logic                  data_write_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  input  logic [1:0]            data_len_i,
  output logic                  data_busy,
  output logic                  data_enable_o,
  output logic [31:0]           data_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  input  logic [7:0]            mem_din
);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            n_q, n_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           buf_q, buf_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  inst_en_q, inst_en_d;
  logic                  data_en_q, data_en_d;
  logic [31:0]           inst_data_q, inst_data_d;
  logic [31:0]           data_rdata_q, data_rdata_d;
  logic                  busy_q, busy_d;

  logic [2:0]            nxt;
  logic [1:0]            cap_idx;
  logic                  data_req;
  logic                  grant_data;

  assign nxt        = cnt_q + 3'd1;
  // In READ cycle k the RAM returns the byte addressed one cycle earlier
  assign cap_idx    = cnt_q[1:0] - 2'd1;
  assign data_req   = data_read_i | data_write_i;
  assign grant_data = data_req & (DATA_FIRST | ~inst_read_i);

  // Next-state, beat sequencing and registered-output values
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    n_d          = n_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    buf_d        = buf_q;
    mem_a_d      = '0;
    mem_dout_d   = 8'h00;
    mem_wr_d     = 1'b0;
    inst_en_d    = 1'b0;
    data_en_d    = 1'b0;
    inst_data_d  = inst_data_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          owner_d = OWN_DATA;
          addr_d  = data_addr_i;
          n_d     = len_to_beats(data_len_i);
          wdata_d = data_wdata_i;
          cnt_d   = 3'd0;
          buf_d   = ZeroWord;
          mem_a_d = data_addr_i;
          if (data_write_i) begin
            state_d    = ST_WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = data_wdata_i[7:0];
          end else begin
            state_d = ST_READ;
          end
        end else if (inst_read_i) begin
          owner_d = OWN_INST;
          addr_d  = inst_addr_i;
          n_d     = 3'd4;
          cnt_d   = 3'd0;
          buf_d   = ZeroWord;
          mem_a_d = inst_addr_i;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if ((owner_q == OWN_INST) && inst_cancel_i) begin
          // Branch flush: drop the fetch and any byte still in flight
          state_d = ST_IDLE;
        end else begin
          if (cnt_q != 3'd0) begin
            buf_d = buf_q | (32'(mem_din) << {cap_idx, 3'b000});
          end
          if (nxt < n_q) begin
            mem_a_d = addr_q + ADDR_WIDTH'(nxt);
          end
          if (cnt_q == n_q) begin
            state_d = ST_IDLE;
            if (owner_q == OWN_INST) begin
              inst_en_d   = 1'b1;
              inst_data_d = buf_d;
            end else begin
              data_en_d    = 1'b1;
              data_rdata_d = buf_d;
            end
          end else begin
            cnt_d = nxt;
          end
        end
      end

      ST_WRITE: begin
        if (nxt < n_q) begin
          mem_a_d    = addr_q + ADDR_WIDTH'(nxt);
          mem_dout_d = byte_of(wdata_q, nxt[1:0]);
          mem_wr_d   = 1'b1;
          cnt_d      = nxt;
        end else begin
          state_d   = ST_IDLE;
          data_en_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything, including partial data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      addr_q       <= '0;
      n_q          <= 3'd0;
      cnt_q        <= 3'd0;
      wdata_q      <= ZeroWord;
      buf_q        <= ZeroWord;
      mem_a_q      <= '0;
      mem_dout_q   <= 8'h00;
      mem_wr_q     <= 1'b0;
      inst_en_q    <= 1'b0;
      data_en_q    <= 1'b0;
      inst_data_q  <= ZeroWord;
      data_rdata_q <= ZeroWord;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      n_q          <= n_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      buf_q        <= buf_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      inst_en_q    <= inst_en_d;
      data_en_q    <= data_en_d;
      inst_data_q  <= inst_data_d;
      data_rdata_q <= data_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign inst_busy     = busy_q;
  assign data_busy     = busy_q;
  assign inst_enable_o = inst_en_q;
  assign data_enable_o = data_en_q;
  assign inst_data_o   = inst_data_q;
  assign data_rdata_o  = data_rdata_q;
  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = mem_wr_q;

endmodule
